// File: rtl/inst_mem_loader.sv
// inst_mem_loader: byte-stream program loader for the instruction memory
// write port. Receives a count byte N, then 4*N data bytes (little-endian
// words), and writes the words to consecutive addresses from BASE_ADDR.
// The core is held stalled until a load completes successfully.
//
// Optional feature macro: INST_MEM_LOADER_CHECKSUM_EN
//   When defined, a trailing checksum byte (XOR of all data bytes) is
//   expected and verified before the load is declared done.
module inst_mem_loader #(
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              hold_core
);

  // Largest word count that still fits between BASE_ADDR and the top address.
  localparam logic [31:0] MAX_WORDS = 32'((1 << ADDR_W) - BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    S_CHECK = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_xfer;
  logic                w_ready;
  logic                w_start_ok;
  logic [7:0]          r_words;      // words still to be written
  logic [ADDR_W-1:0]   r_addr;       // address of the next word
  logic [1:0]          r_byte;       // byte lane of the next data byte
  logic [23:0]         r_asm;        // lower three bytes of the word in progress
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_done;
  logic                r_err;
  logic                r_hold;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;       // running XOR of data bytes
`endif

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  assign w_ready = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);
  assign busy    = (r_state == S_COUNT) || (r_state == S_DATA) ||
                   (r_state == S_WRITE) || (r_state == S_CHECK);
`else
  assign w_ready = (r_state == S_COUNT) || (r_state == S_DATA);
  assign busy    = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_WRITE);
`endif

  assign w_xfer     = in_valid && w_ready;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                (r_state == S_ERROR));

  assign in_ready  = w_ready;
  assign mem_we    = (r_state == S_WRITE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign err       = r_err;
  assign hold_core = r_hold;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always updated with non-blocking (<=) so
    // every flop samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // w_next unassigned, which would infer a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start_ok) w_next = S_COUNT;
      end
      S_COUNT: begin
        if (w_xfer) begin
          if (in_data == 8'd0) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            w_next = S_CHECK;
`else
            w_next = S_DONE;
`endif
          end else if ({24'd0, in_data} > MAX_WORDS) begin
            w_next = S_ERROR;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_xfer && (r_byte == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (r_words == 8'd1) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_DATA;
        end
      end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_xfer) w_next = (in_data == r_csum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Word assembly, address/count bookkeeping and write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words     <= '0;
      r_addr      <= '0;
      r_byte      <= '0;
      r_asm       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_COUNT: begin
          if (w_xfer) begin
            r_words <= in_data;
            r_addr  <= ADDR_W'(BASE_ADDR);
            r_byte  <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_byte <= r_byte + 2'd1;
            case (r_byte)
              2'd0:    r_asm[7:0]   <= in_data;
              2'd1:    r_asm[15:8]  <= in_data;
              2'd2:    r_asm[23:16] <= in_data;
              default: begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= {in_data, r_asm};
              end
            endcase
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + 1'b1;
          r_words <= r_words - 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  // Running checksum: cleared at load start, folded with every data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_csum <= '0;
    else if (w_start_ok)                      r_csum <= '0;
    else if ((r_state == S_DATA) && w_xfer)   r_csum <= r_csum ^ in_data;
  end
`endif

  // Registered status flags, following the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_hold <= 1'b1;
    end else begin
      r_done <= (w_next == S_DONE);
      r_err  <= (w_next == S_ERROR);
      r_hold <= (w_next != S_DONE);
    end
  end

endmodule
